operand_fetch: RTL
==================

Name: operand_fetch

Overview:
- Stage directly upstream of the execute (Process/ALU) stage of the 8051-style MCU core.
- Accepts one decoded instruction with its operand bytes and resolves operands A and B from ACC, working registers, direct internal RAM, indirect @Ri, immediate or bit address.
- Presents a_data/b_data, bit locations, bit_en, alu_op and instruction to the execute stage behind a valid/ready handshake.
- Internal RAM is accessed through a single synchronous read port.

Parameters:
- BIT_BASE, 8'h20, byte address of the bit-addressable RAM region.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  decoded instruction available.
- in_ready  output  1  stage can accept; high only in IDLE.
- instruction  input  8  opcode byte.
- op1  input  8  first operand byte following the opcode.
- op2  input  8  second operand byte following the opcode.
- a_src  input  3  source select for operand A; encoding below.
- b_src  input  3  source select for operand B; same encoding.
- alu_op_in  input  4  ALU opcode, passed through unchanged.
- bit_en_in  input  1  bit-operation flag, passed through unchanged.
- acc  input  8  current accumulator.
- psw_in  input  8  current PSW; RS1:RS0 = psw_in[4:3].
- ram_rd_en  output  1  RAM read strobe.
- ram_addr  output  8  RAM read address.
- ram_rdata  input  8  read data, valid the cycle after ram_rd_en.
- out_valid  output  1  operands valid to execute stage.
- out_ready  input  1  execute stage accepts.
- a_data, b_data  output  8  resolved operands.
- a_bit_location, b_bit_location  output  3  bit index within the byte.
- bit_en  output  1  registered copy of bit_en_in.
- alu_op  output  4  registered copy of alu_op_in.
- instruction_out  output  8  registered copy of instruction.

Behaviour:
- Source encoding:
  - 0 ACC
  - 1 Rn: RAM addr {psw[4:3], instruction[2:0]}
  - 2 direct addr op1
  - 3 direct addr op2
  - 4 @Ri: pointer addr {psw[4:3], 2'b00, instruction[0]}, then data at the pointer value
  - 5 immediate op1
  - 6 immediate op2
  - 7 bit address: op1 for A, op2 for B
- Bit address resolution for bit address b:
  - b < 8'h80: byte = BIT_BASE + b[6:3].
  - Otherwise: byte = {b[7:3], 3'b000}.
  - Bit location = b[2:0].
  - For non-bit sources the bit location is 0.
- Accept: on in_valid && in_ready, all inputs are latched, including acc and psw_in. Later changes on those inputs are ignored for this instruction.
- FSM states: IDLE, A_ISSUE, A_CAP, A_PTR, B_ISSUE, B_CAP, B_PTR, OUT.
- Per-operand sequence:
  - Sources 0/5/6 need no RAM access.
  - Sources 1/2/3/7 do one read: ISSUE drives ram_rd_en=1 with the address, CAP latches ram_rdata.
  - Source 4 does two reads: ISSUE reads the pointer; PTR issues the read at the captured pointer value; CAP latches the data.
- Each RAM read costs exactly 2 cycles. Operand A completes fully before operand B starts.
- Latency: out_valid rises 1 + 2*(number of RAM reads) cycles after the accept edge. Range 1..9 cycles.
- OUT state:
  - out_valid=1; all outputs held stable until out_ready=1.
  - On the out_ready cycle the FSM goes to IDLE; in_ready is high the following cycle. No back-to-back accept in the same cycle.
- ram_rd_en is high only in ISSUE and PTR states; ram_addr is 0 otherwise.
- No forwarding: A and B at the same address perform two independent reads.
- Reset (rst_n=0 at a clock edge, including mid-operation):
  - FSM goes to IDLE; any in-flight instruction is dropped.
  - out_valid=0, ram_rd_en=0, ram_addr=0, in_ready=1 after the edge.
  - All data, bit-location, alu_op, bit_en and instruction_out outputs reset to 0.
- in_valid while busy is ignored; upstream holds it.

Test Plan:
- a_src=0, b_src=5, acc=8'h3C, op1=8'h05 → out_valid 1 cycle after accept; a_data=3C, b_data=05; ram_rd_en never asserted.
- psw_in[4:3]=2'b10, instruction=8'h27, a_src=0, b_src=4, RAM[11h]=8'h40, RAM[40h]=8'h99 → reads 11h, then 40h; b_data=99; out_valid at accept+5.
- a_src=7, op1=8'h2B, RAM[25h]=8'h08 → ram_addr=25h; a_data=08; a_bit_location=3. Then op1=8'h93 → ram_addr=90h; a_bit_location=3.
- a_src=2, b_src=3, op1=op2=8'h30, RAM[30h]=8'h7E → two reads of 30h; a_data=b_data=7E; out_valid at accept+5.
- out_ready held low 4 cycles in OUT → outputs and out_valid stable, in_ready=0. out_ready=1 → IDLE next cycle, new accept possible.
- rst_n low during A_PTR of an @Ri fetch → next cycle in IDLE, out_valid=0, ram_rd_en=0. A fresh instruction then completes normally.

Source files
------------

// File: rtl/operand_fetch.sv
// Operand fetch stage of the 8051-style core: resolves operands A and B from
// ACC, registers, direct/indirect RAM, immediates or bit addresses for the ALU.
module operand_fetch #(
  parameter logic [7:0] BIT_BASE = 8'h20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] instruction,
  input  logic [7:0] op1,
  input  logic [7:0] op2,
  input  logic [2:0] a_src,
  input  logic [2:0] b_src,
  input  logic [3:0] alu_op_in,
  input  logic       bit_en_in,
  input  logic [7:0] acc,
  input  logic [7:0] psw_in,
  output logic       ram_rd_en,
  output logic [7:0] ram_addr,
  input  logic [7:0] ram_rdata,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] a_data,
  output logic [7:0] b_data,
  output logic [2:0] a_bit_location,
  output logic [2:0] b_bit_location,
  output logic       bit_en,
  output logic [3:0] alu_op,
  output logic [7:0] instruction_out,
  output logic [2:0] fsm_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; the
  // sender holds valid and its payload stable until that edge.
  typedef enum logic [2:0] {
    IDLE, A_ISSUE, A_CAP, A_PTR, B_ISSUE, B_CAP, B_PTR, OUT
  } state_t;

  state_t     state, nxt;
  logic [7:0] op1_q, op2_q, ptr_q;
  logic [2:0] a_src_q, b_src_q;
  logic [1:0] rs_q;
  logic       ptr_ph;

  function automatic logic needs_ram(input logic [2:0] s);
    return (s == 3'd1) || (s == 3'd2) || (s == 3'd3) || (s == 3'd4) || (s == 3'd7);
  endfunction

  function automatic logic [7:0] bit_byte(input logic [7:0] b);
    if (!b[7]) return BIT_BASE + {4'b0000, b[6:3]};
    else       return {b[7:3], 3'b000};
  endfunction

  function automatic logic [7:0] src_addr(input logic [2:0] s, input logic [7:0] bit_op,
                                          input logic [2:0] instr_lo, input logic [1:0] rs,
                                          input logic [7:0] o1, input logic [7:0] o2);
    case (s)
      3'd1:    return {3'b000, rs, instr_lo};
      3'd2:    return o1;
      3'd3:    return o2;
      3'd4:    return {3'b000, rs, 2'b00, instr_lo[0]};
      3'd7:    return bit_byte(bit_op);
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] imm_val(input logic [2:0] s, input logic [7:0] a,
                                         input logic [7:0] o1, input logic [7:0] o2);
    case (s)
      3'd0:    return a;
      3'd5:    return o1;
      3'd6:    return o2;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [2:0] bit_loc(input logic [2:0] s, input logic [2:0] b_lo);
    return (s == 3'd7) ? b_lo : 3'd0;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      op1_q           <= '0;
      op2_q           <= '0;
      ptr_q           <= '0;
      a_src_q         <= '0;
      b_src_q         <= '0;
      rs_q            <= '0;
      ptr_ph          <= 1'b0;
      a_data          <= '0;
      b_data          <= '0;
      a_bit_location  <= '0;
      b_bit_location  <= '0;
      bit_en          <= 1'b0;
      alu_op          <= '0;
      instruction_out <= '0;
    end else begin
      state <= nxt;
      case (state)
        IDLE: if (in_valid) begin
          op1_q           <= op1;
          op2_q           <= op2;
          a_src_q         <= a_src;
          b_src_q         <= b_src;
          rs_q            <= psw_in[4:3];
          ptr_ph          <= 1'b0;
          // Register-free sources are resolved here; RAM sources overwrite later.
          a_data          <= imm_val(a_src, acc, op1, op2);
          b_data          <= imm_val(b_src, acc, op1, op2);
          a_bit_location  <= bit_loc(a_src, op1[2:0]);
          b_bit_location  <= bit_loc(b_src, op2[2:0]);
          bit_en          <= bit_en_in;
          alu_op          <= alu_op_in;
          instruction_out <= instruction;
        end
        A_CAP: begin
          if (a_src_q == 3'd4 && !ptr_ph) begin
            ptr_q  <= ram_rdata;
            ptr_ph <= 1'b1;
          end else begin
            a_data <= ram_rdata;
            ptr_ph <= 1'b0;
          end
        end
        B_CAP: begin
          if (b_src_q == 3'd4 && !ptr_ph) begin
            ptr_q  <= ram_rdata;
            ptr_ph <= 1'b1;
          end else begin
            b_data <= ram_rdata;
            ptr_ph <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    nxt       = state;
    ram_rd_en = 1'b0;
    ram_addr  = 8'h00;
    case (state)
      IDLE: if (in_valid) begin
        if (needs_ram(a_src))      nxt = A_ISSUE;
        else if (needs_ram(b_src)) nxt = B_ISSUE;
        else                       nxt = OUT;
      end
      A_ISSUE: begin
        ram_rd_en = 1'b1;
        ram_addr  = src_addr(a_src_q, op1_q, instruction_out[2:0], rs_q, op1_q, op2_q);
        nxt       = A_CAP;
      end
      A_CAP: begin
        if (a_src_q == 3'd4 && !ptr_ph) nxt = A_PTR;
        else if (needs_ram(b_src_q))    nxt = B_ISSUE;
        else                            nxt = OUT;
      end
      A_PTR: begin
        ram_rd_en = 1'b1;
        ram_addr  = ptr_q;
        nxt       = A_CAP;
      end
      B_ISSUE: begin
        ram_rd_en = 1'b1;
        ram_addr  = src_addr(b_src_q, op2_q, instruction_out[2:0], rs_q, op1_q, op2_q);
        nxt       = B_CAP;
      end
      B_CAP: begin
        if (b_src_q == 3'd4 && !ptr_ph) nxt = B_PTR;
        else                            nxt = OUT;
      end
      B_PTR: begin
        ram_rd_en = 1'b1;
        ram_addr  = ptr_q;
        nxt       = B_CAP;
      end
      OUT: if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUT);
  assign fsm_state = state;

endmodule
